// File: rtl/debounce_pkg.sv
// ============================================================================
// Module      : debounce_pkg
// Description : Shared constants and width helpers for the debounce_pass block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package debounce_pkg;

  localparam int N_CH_DEF      = 2;
  localparam int DB_CYCLES_DEF = 4;
  localparam int RST_VAL_DEF   = 0;
  localparam int SYNC_STAGES   = 2;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < value) begin
        res = i + 1;
      end
    end
    return res;
  endfunction

  // A single-cycle debounce still needs a 1-bit counter to stay well formed.
  function automatic int cnt_width(input int db_cycles);
    int w;
    w = clog2(db_cycles);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/debounce_ch.sv
// ============================================================================
// Module      : debounce_ch
// Description : One channel: 2-flop synchroniser, debounce counter, registered
//               level, and rise/fall pulses when DEBOUNCE_EDGE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module debounce_ch
  import debounce_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int RST_VAL   = RST_VAL_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  localparam int              CNT_W   = cnt_width(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);
  localparam logic             RST_BIT = (RST_VAL != 0);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;
  logic                   dout_q;
  logic                   dout_d;
  logic                   sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    cnt_d  = '0;
    dout_d = dout_q;
    // Any sample agreeing with the current level restarts the count.
    if (sync_out != dout_q) begin
      if (cnt_q == CNT_MAX) begin
        dout_d = sync_out;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RST_BIT}};
      cnt_q  <= '0;
      dout_q <= RST_BIT;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

`ifdef DEBOUNCE_EDGE_EN
  logic rise_q;
  logic rise_d;
  logic fall_q;
  logic fall_d;

  always_comb begin
    rise_d = dout_d & ~dout_q;
    fall_d = ~dout_d & dout_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/debounce_pass.sv
// ============================================================================
// Module      : debounce_pass
// Description : N_CH-channel synchronise-and-debounce bank for pad inputs.
//               Optional edge pulses enabled by macro DEBOUNCE_EDGE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module debounce_pass
  import debounce_pkg::*;
#(
  parameter int N_CH      = N_CH_DEF,
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int RST_VAL   = RST_VAL_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] din,
  output logic [N_CH-1:0] dout,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_ch #(
      .DB_CYCLES (DB_CYCLES),
      .RST_VAL   (RST_VAL)
    ) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (din[i]),
      .dout  (dout[i]),
      .rise  (rise[i]),
      .fall  (fall[i])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_debounce_pass.sv
// ============================================================================
// Module      : tb_debounce_pass
// Description : Directed bench for debounce_pass (N_CH=2, DB_CYCLES=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_debounce_pass;

`ifdef DEBOUNCE_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [1:0] din;
  logic [1:0] dout;
  logic [1:0] rise;
  logic [1:0] fall;

  int n_vec;
  int n_err;

  debounce_pass #(
    .N_CH      (2),
    .DB_CYCLES (4),
    .RST_VAL   (0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (din),
    .dout  (dout),
    .rise  (rise),
    .fall  (fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [1:0] e_dout,
                         input logic [1:0] e_rise, input logic [1:0] e_fall);
    chk({tag, "_dout"}, 32'(dout), 32'(e_dout));
    chk({tag, "_rise"}, 32'(rise), 32'(e_rise));
    chk({tag, "_fall"}, 32'(fall), 32'(e_fall));
  endtask

  // Drive a clean step and expect dout to follow on the 6th edge, with
  // a one-cycle edge pulse when edge outputs are built in.
  task automatic expect_step(input string tag, input logic [1:0] old_v, input logic [1:0] new_v);
    logic [1:0] e_d;
    logic [1:0] e_r;
    logic [1:0] e_f;
    din = new_v;
    for (int k = 1; k <= 7; k++) begin
      tick();
      e_d = (k >= 6) ? new_v : old_v;
      e_r = (k == 6 && EDGE_EN) ? (new_v & ~old_v) : 2'b00;
      e_f = (k == 6 && EDGE_EN) ? (~new_v & old_v) : 2'b00;
      chk_all($sformatf("%s_e%0d", tag, k), e_d, e_r, e_f);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    din   = 2'b11;

    for (int k = 0; k < 3; k++) begin
      tick();
      chk_all($sformatf("rst_hold%0d", k), 2'b00, 2'b00, 2'b00);
    end
    rst_n = 1'b1;
    expect_step("rst_rel", 2'b00, 2'b11);
    expect_step("fall_all", 2'b11, 2'b00);

    // Three-cycle pulse on channel 0 must be swallowed.
    din = 2'b01;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_all($sformatf("glitch_hi%0d", k), 2'b00, 2'b00, 2'b00);
    end
    din = 2'b00;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_all($sformatf("glitch_lo%0d", k), 2'b00, 2'b00, 2'b00);
    end
    expect_step("post_glitch", 2'b00, 2'b01);
    expect_step("ch0_back", 2'b01, 2'b00);

    expect_step("step1_up", 2'b00, 2'b10);
    expect_step("step1_dn", 2'b10, 2'b00);

    // Mid-count asynchronous reset while dout=10 and channel 0 is counting.
    expect_step("pre_mid", 2'b00, 2'b10);
    din = 2'b11;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_all($sformatf("mid_cnt%0d", k), 2'b10, 2'b00, 2'b00);
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("mid_rst_async", 2'b00, 2'b00, 2'b00);
    tick();
    chk_all("mid_rst_held", 2'b00, 2'b00, 2'b00);
    rst_n = 1'b1;
    expect_step("after_rst", 2'b00, 2'b11);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
